dvs_event_queue: RTL

Event FIFO that buffers timestamped DVS events from the camera-side capture logic and serves them to one or more RAVENS-side readers over the FIFO bus (req/grant/rd_en/event). It is the responder end of the FIFO bus: it arbitrates among requesting readers, issues grants, pops on read enable and presents the event on a registered output bus. Overflowing writes are dropped and counted.

---
 rtl/dvs_ravens_pkg.sv | 21 ++
 rtl/dvs_event_queue_rr_arbiter.sv | 59 +++++
 rtl/dvs_event_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dvs_ravens_pkg.sv
// +--------------------------------------------------------------------+
// | dvs_ravens_pkg: shared event width, queue depth and arbiter states  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package dvs_ravens_pkg;

  localparam int EVENT_BITS        = 16;
  localparam int EVENT_QUEUE_DEPTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RD_WAIT = 2'd2,
    ARB_HOLD    = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dvs_event_queue_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | dvs_event_queue_rr_arbiter: round-robin one-hot reader select       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dvs_event_queue_rr_arbiter #(
  parameter int NUM_READERS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_READERS-1:0] req_i,
  input  logic                   en_i,
  output logic [NUM_READERS-1:0] gnt_o
);

  localparam int IDXW = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] sel;
  logic            any;
  int              best_d;

  // Pick the requester closest (in rotation order) to the priority pointer.
  always_comb begin
    sel    = '0;
    any    = 1'b0;
    best_d = NUM_READERS;
    gnt_o  = '0;
    for (int j = 0; j < NUM_READERS; j++) begin
      if (req_i[j] && (((j + NUM_READERS - int'(ptr_q)) % NUM_READERS) < best_d)) begin
        best_d = (j + NUM_READERS - int'(ptr_q)) % NUM_READERS;
        sel    = IDXW'(j);
        any    = 1'b1;
      end
    end
    for (int j = 0; j < NUM_READERS; j++) begin
      gnt_o[j] = any && (int'(sel) == j);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && any) begin
      ptr_d = (sel == IDXW'(NUM_READERS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dvs_event_queue.sv
// +--------------------------------------------------------------------+
// | dvs_event_queue: DVS event FIFO serving readers over the FIFO bus   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dvs_event_queue
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH        = EVENT_QUEUE_DEPTH,
  parameter int NUM_READERS  = 1,
  parameter int OVF_CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [EVENT_BITS-1:0]      wr_event_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [OVF_CNT_BITS-1:0]    overflow_cnt_o,
  input  logic [NUM_READERS-1:0]     fifo_req_i,
  output logic [NUM_READERS-1:0]     fifo_grant_o,
  input  logic [NUM_READERS-1:0]     fifo_rd_en_i,
  output logic [EVENT_BITS-1:0]      fifo_event_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EVENT_BITS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic [OVF_CNT_BITS-1:0] ovf_q;
  logic [EVENT_BITS-1:0]   event_q;
  logic [NUM_READERS-1:0]  gnt_q, gnt_d, arb_gnt;
  arb_state_e              state_q, state_d;

  logic full, empty, push, pop, arb_req;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Full is judged before any same-cycle pop, so a write at full is always dropped.
  assign push    = wr_en_i && !full;
  assign pop     = (state_q == ARB_RD_WAIT) && |(fifo_rd_en_i & gnt_q);
  assign arb_req = (state_q == ARB_IDLE) && !empty && |fifo_req_i;

  dvs_event_queue_rr_arbiter #(
    .NUM_READERS(NUM_READERS)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (fifo_req_i),
    .en_i  (arb_req),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_req) begin
          gnt_d   = arb_gnt;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT:   state_d = ARB_RD_WAIT;
      ARB_RD_WAIT: state_d = ARB_HOLD;
      ARB_HOLD:    state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_event_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      event_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q  <= rptr_q + 1'b1;
        event_q <= mem_q[rptr_q];
      end
      if (wr_en_i && full && (ovf_q != '1)) begin
        ovf_q <= ovf_q + 1'b1;
      end
    end
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign count_o        = count_q;
  assign overflow_cnt_o = ovf_q;
  assign fifo_grant_o   = (state_q == ARB_GRANT) ? gnt_q : '0;
  assign fifo_event_o   = event_q;

endmodule

`default_nettype wire
